// File: rtl/exec_stage_pkg.sv
// Shared constants for the execute-stage slice: ALU op codes and datapath defaults.
package exec_stage_pkg;

  localparam int WIDTH_DEF     = 32;
  localparam int LUI_SHIFT_DEF = 16;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1101;

endpackage

// File: rtl/exec_alu_core.sv
// Combinational ALU: result, zero and signed-overflow flags for one operation.
module exec_alu_core
  import exec_stage_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int LUI_SHIFT = LUI_SHIFT_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // Operation select; SLT uses a true signed compare so it stays correct when A-B overflows.
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (alu_ctrl_i)
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_ADD: begin
        result_o   = sum;
        overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        result_o   = diff;
        overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SLT: result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_LUI: result_o = b_i << LUI_SHIFT;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand-B mux, PC incrementer and ALU, all outputs registered one cycle.
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int LUI_SHIFT = LUI_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic             alu_src,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] operand_b_d;
  logic [WIDTH-1:0] pc_plus4_d;
  logic [WIDTH-1:0] alu_result_d;
  logic             zero_d;
  logic             overflow_d;

  logic             valid_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic [WIDTH-1:0] operand_b_q;
  logic [WIDTH-1:0] alu_result_q;
  logic             zero_q;
  logic             overflow_q;

  assign operand_b_d = alu_src ? imm_ext : rt_data;
  assign pc_plus4_d  = pc + WIDTH'(4);

  exec_alu_core #(
    .WIDTH     (WIDTH),
    .LUI_SHIFT (LUI_SHIFT)
  ) u_alu (
    .a_i        (rs_data),
    .b_i        (operand_b_d),
    .alu_ctrl_i (alu_ctrl),
    .result_o   (alu_result_d),
    .zero_o     (zero_d),
    .overflow_o (overflow_d)
  );

  // Valid follows in_valid every cycle; data and flags only load on a valid cycle and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_plus4_q   <= '0;
      operand_b_q  <= '0;
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        pc_plus4_q   <= pc_plus4_d;
        operand_b_q  <= operand_b_d;
        alu_result_q <= alu_result_d;
        zero_q       <= zero_d;
        overflow_q   <= overflow_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign pc_plus4   = pc_plus4_q;
  assign operand_b  = operand_b_q;
  assign alu_result = alu_result_q;
  assign zero       = zero_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized ops against a reference model.
module tb_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] pc, rs_data, rt_data, imm_ext;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic [31:0] pc_plus4, operand_b, alu_result;
  logic        zero, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected registered state, maintained from the rules rather than from the DUT.
  logic        e_valid;
  logic [31:0] e_pc4, e_opb, e_res;
  logic        e_zero, e_ovf;

  exec_stage #(.WIDTH(32), .LUI_SHIFT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .pc         (pc),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .imm_ext    (imm_ext),
    .alu_src    (alu_src),
    .alu_ctrl   (alu_ctrl),
    .out_valid  (out_valid),
    .pc_plus4   (pc_plus4),
    .operand_b  (operand_b),
    .alu_result (alu_result),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'(longint'(a) + longint'(b));
      4'b0110: return 32'(longint'(a) - longint'(b));
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1101: return 32'(longint'(b) * 65536);
      default: return 32'd0;
    endcase
  endfunction

  // Overflow: the exact signed result does not fit in 32 signed bits.
  function automatic logic m_ovf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint r;
    sa = a;
    sb = b;
    if (c == 4'b0010)      r = longint'(sa) + longint'(sb);
    else if (c == 4'b0110) r = longint'(sa) - longint'(sb);
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic model_reset();
    e_valid = 0; e_pc4 = 0; e_opb = 0; e_res = 0; e_zero = 0; e_ovf = 0;
  endtask

  // Drive one cycle of inputs, clock it in, then advance the model and leave us 1ns past the edge.
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] a, input logic [31:0] t,
                      input logic [31:0] im, input logic src, input logic [3:0] c);
    logic [31:0] b;
    in_valid = v; pc = p; rs_data = a; rt_data = t; imm_ext = im; alu_src = src; alu_ctrl = c;
    @(posedge clk);
    #1;
    b = src ? im : t;
    e_valid = v;
    if (v) begin
      e_pc4  = 32'((longint'(p) + 4) % 64'h1_0000_0000);
      e_opb  = b;
      e_res  = m_result(c, a, b);
      e_zero = (e_res == 0);
      e_ovf  = m_ovf(c, a, b);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    in_valid = 0; pc = 0; rs_data = 0; rt_data = 0; imm_ext = 0; alu_src = 0; alu_ctrl = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, pc_plus4, operand_b, alu_result, zero, overflow} !== '0) begin
      n_fail++; $display("FAIL reset_initial: got valid=%0b res=%h pc4=%h", out_valid, alu_result, pc_plus4);
    end
    rst_n = 1;
    step(1, 32'h100, 32'h7FFFFFFF, 32'd1, 0, 0, 4'b0010);
    n_checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h80000000) begin
      n_fail++; $display("FAIL reset_preload: got valid=%0b res=%h", out_valid, alu_result);
    end
    // Mid-cycle asynchronous assertion while a valid op is being presented.
    in_valid = 1; rs_data = 32'd9; rt_data = 32'd9; alu_ctrl = 4'b0010;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if ({out_valid, pc_plus4, operand_b, alu_result, zero, overflow} !== '0) begin
      n_fail++; $display("FAIL reset_async: got valid=%0b res=%h pc4=%h opb=%h z=%0b ovf=%0b",
                         out_valid, alu_result, pc_plus4, operand_b, zero, overflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 32'h40, 32'd1, 32'd2, 32'd3, 0, 4'b0010);
    step(0, 32'h44, 32'd1, 32'd2, 32'd3, 0, 4'b0010);
    n_checks++;
    if ({out_valid, pc_plus4, operand_b, alu_result, zero, overflow} !== '0) begin
      n_fail++; $display("FAIL reset_release_idle: got valid=%0b res=%h pc4=%h", out_valid, alu_result, pc_plus4);
    end
  endtask

  task automatic test_add_sub();
    step(1, 0, 32'd5, 32'd3, 32'hDEAD, 0, 4'b0010);
    n_checks++;
    if (alu_result !== 32'd8 || zero !== 1'b0 || out_valid !== 1'b1 || operand_b !== 32'd3) begin
      n_fail++; $display("FAIL add_rt: got res=%h z=%0b v=%0b opb=%h, want 8 0 1 3", alu_result, zero, out_valid, operand_b);
    end
    step(1, 0, 32'd5, 32'd3, 32'hDEAD, 0, 4'b0110);
    n_checks++;
    if (alu_result !== 32'd2 || zero !== 1'b0) begin
      n_fail++; $display("FAIL sub_rt: got res=%h z=%0b, want 2 0", alu_result, zero);
    end
    step(1, 0, 32'd7, 32'd7, 32'd1, 0, 4'b0110);
    n_checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL sub_equal: got res=%h z=%0b ovf=%0b, want 0 1 0", alu_result, zero, overflow);
    end
  endtask

  task automatic test_immediate();
    step(1, 0, 32'h10, 32'h55, 32'hFFFFFFFC, 1, 4'b0010);
    n_checks++;
    if (alu_result !== 32'h0000000C || operand_b !== 32'hFFFFFFFC || overflow !== 1'b0) begin
      n_fail++; $display("FAIL imm_add: got res=%h opb=%h ovf=%0b, want 0000000c fffffffc 0", alu_result, operand_b, overflow);
    end
  endtask

  task automatic test_logic_lui();
    step(1, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 4'b0000);
    n_checks++;
    if (alu_result !== 32'h00F000F0) begin
      n_fail++; $display("FAIL and: got %h want 00f000f0", alu_result);
    end
    step(1, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 4'b0001);
    n_checks++;
    if (alu_result !== 32'hFFF0FFF0) begin
      n_fail++; $display("FAIL or: got %h want fff0fff0", alu_result);
    end
    step(1, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 4'b1100);
    n_checks++;
    if (alu_result !== 32'h000F000F) begin
      n_fail++; $display("FAIL nor: got %h want 000f000f", alu_result);
    end
    step(1, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00001234, 1, 4'b1101);
    n_checks++;
    if (alu_result !== 32'h12340000) begin
      n_fail++; $display("FAIL lui: got %h want 12340000", alu_result);
    end
  endtask

  task automatic test_slt_overflow();
    step(1, 0, 32'h7FFFFFFF, 32'd1, 0, 0, 4'b0010);
    n_checks++;
    if (alu_result !== 32'h80000000 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL add_ovf: got res=%h ovf=%0b, want 80000000 1", alu_result, overflow);
    end
    step(1, 0, 32'h80000000, 32'd1, 0, 0, 4'b0110);
    n_checks++;
    if (alu_result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
      n_fail++; $display("FAIL sub_ovf: got res=%h ovf=%0b, want 7fffffff 1", alu_result, overflow);
    end
    step(1, 0, 32'h80000000, 32'h7FFFFFFF, 0, 0, 4'b0111);
    n_checks++;
    if (alu_result !== 32'd1 || overflow !== 1'b0 || zero !== 1'b0) begin
      n_fail++; $display("FAIL slt_neg: got res=%h ovf=%0b z=%0b, want 1 0 0", alu_result, overflow, zero);
    end
    step(1, 0, 32'd3, 32'd3, 0, 0, 4'b0111);
    n_checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL slt_equal: got res=%h z=%0b, want 0 1", alu_result, zero);
    end
  endtask

  task automatic test_pc_hold();
    step(1, 32'h00400000, 32'd1, 32'd2, 0, 0, 4'b0010);
    n_checks++;
    if (pc_plus4 !== 32'h00400004) begin
      n_fail++; $display("FAIL pc_inc: got %h want 00400004", pc_plus4);
    end
    step(1, 32'hFFFFFFFC, 32'd20, 32'd2, 0, 0, 4'b0110);
    n_checks++;
    if (pc_plus4 !== 32'h00000000 || alu_result !== 32'd18) begin
      n_fail++; $display("FAIL pc_wrap: got pc4=%h res=%h, want 00000000 00000012", pc_plus4, alu_result);
    end
    step(0, 32'h1000, 32'hAAAA, 32'h5555, 32'h1, 1, 4'b0001);
    n_checks++;
    if (out_valid !== 1'b0 || pc_plus4 !== 32'h0 || alu_result !== 32'd18 || operand_b !== 32'd2 || zero !== 1'b0) begin
      n_fail++; $display("FAIL hold: got v=%0b pc4=%h res=%h opb=%h z=%0b, want 0 0 12 2 0",
                         out_valid, pc_plus4, alu_result, operand_b, zero);
    end
    step(1, 0, 32'hFFFFFFFF, 32'h1234, 0, 0, 4'b1111);
    n_checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL undef_op: got res=%h z=%0b ovf=%0b, want 0 1 0", alu_result, zero, overflow);
    end
  endtask

  task automatic test_random();
    logic [31:0] corner [6];
    logic [3:0]  ops    [9];
    logic [31:0] a, t, im;
    corner = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFC};
    ops    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b0011, 4'b1010};
    for (int i = 0; i < 300; i++) begin
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      t  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      im = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      step(($urandom_range(0, 4) != 0), $urandom, a, t, im, 1'($urandom_range(0, 1)),
           ops[$urandom_range(0, 8)]);
      n_checks++;
      if (out_valid !== e_valid || pc_plus4 !== e_pc4 || operand_b !== e_opb ||
          alu_result !== e_res || zero !== e_zero || overflow !== e_ovf) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b pc4=%h opb=%h res=%h z=%0b ovf=%0b, want v=%0b pc4=%h opb=%h res=%h z=%0b ovf=%0b",
                 i, out_valid, pc_plus4, operand_b, alu_result, zero, overflow,
                 e_valid, e_pc4, e_opb, e_res, e_zero, e_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_immediate();
    test_logic_lui();
    test_slt_overflow();
    test_pc_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute-stage datapath slice of the single-cycle MIPS-style core.
- Combines the PC+4 incrementer, the ALU second-operand select mux and the ALU into one registered block.
- Sits between the register file / sign-extend / ALU-control logic upstream and the data memory / write-back mux / branch logic downstream.
- All outputs are registered with one-cycle latency.

Parameters:
- WIDTH, 32, datapath width of operands, result and PC.
- LUI_SHIFT, 16, left-shift amount applied by the LUI operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies the inputs this cycle
- pc  input  WIDTH  current program counter
- rs_data  input  WIDTH  register-file read port 1 (ALU operand A)
- rt_data  input  WIDTH  register-file read port 2
- imm_ext  input  WIDTH  sign-extended immediate
- alu_src  input  1  0 selects rt_data, 1 selects imm_ext as operand B
- alu_ctrl  input  4  operation code from ALU control
- out_valid  output  1  registered in_valid
- pc_plus4  output  WIDTH  registered pc+4
- operand_b  output  WIDTH  registered selected operand B (store-data / debug)
- alu_result  output  WIDTH  registered ALU result (also the memory address)
- zero  output  1  registered (alu_result == 0)
- overflow  output  1  registered signed overflow flag

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, including out_valid.
  - Release is synchronous to the next rising clk.
  - Reset asserted mid-operation discards the in-flight result.
- Latency: outputs reflect the inputs sampled at the previous rising edge.
- in_valid=1: all output registers load on the edge.
- in_valid=0: out_valid loads 0; data outputs and flags hold their previous values.
- No backpressure.
- Operand B: alu_src ? imm_ext : rt_data.
- pc_plus4: pc + 4, modulo 2^WIDTH; 0xFFFFFFFC wraps to 0x00000000.
- ALU operations, A = rs_data, B = operand B:
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^WIDTH
  - 0110 SUB: A - B, modulo 2^WIDTH
  - 0111 SLT: 1 if signed A < signed B, else 0
  - 1100 NOR: ~(A | B)
  - 1101 LUI: B << LUI_SHIFT, A ignored
  - any other code: result 0
- zero: 1 exactly when the result is 0. This includes undefined codes, which therefore give zero=1.
- overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from A.
  - Forced 0 for all other codes.
  - Overflow never modifies the result; it wraps.
- SLT compares using the signed comparison, not the sign of the subtraction result, so overflow cases such as 0x80000000 < 0x7FFFFFFF give 1.

Decomposition:
- Shared package holds:
  - the ALU op constants (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100, ALU_LUI=4'b1101)
  - the WIDTH default
  - the LUI_SHIFT default
- One natural sub-module: exec_alu_core, a purely combinational ALU producing result, zero and overflow.
- exec_stage wraps exec_alu_core with the operand mux, the PC incrementer and the output registers.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately. Release, in_valid=0 -> outputs stay 0.
- ADD/SUB via rt: rs=5, rt=3, alu_src=0.
  - ctrl 0010 -> next cycle alu_result=8, zero=0, out_valid=1.
  - ctrl 0110 -> 2.
  - rs=rt=7 with SUB -> 0, zero=1.
- Immediate path: rs=0x10, imm=0xFFFFFFFC, alu_src=1, ADD -> 0x0000000C, operand_b=0xFFFFFFFC. Covers store/load address generation.
- Logic and LUI: rs=0xF0F0F0F0, rt=0x0FF00FF0:
  - AND -> 0x00F000F0
  - OR -> 0xFFF0FFF0
  - NOR -> 0x000F000F
  - LUI with imm=0x00001234 -> 0x12340000
- SLT and overflow:
  - 0x7FFFFFFF ADD 1 -> 0x80000000, overflow=1.
  - SLT with A=0x80000000, B=0x7FFFFFFF -> 1.
  - SLT with A=3, B=3 -> 0, zero=1.
- PC and hold:
  - pc=0x00400000 -> pc_plus4=0x00400004.
  - pc=0xFFFFFFFC -> 0.
  - Drop in_valid -> out_valid=0 and data outputs unchanged.
  - Undefined ctrl 1111 -> result 0, zero=1.
